// File: rtl/imem_load_arbiter_pkg.sv
// Shared definitions for the instruction-ROM load arbiter.
//   state_t      : arbiter FSM states (2-bit encoding)
//   IMEM_ADDR_W  : default prgrom word-address width (pc[15:2])
//   BYTE_LANES   : bytes per 32-bit prgrom word
package imem_load_arbiter_pkg;

    localparam int IMEM_ADDR_W = 14;
    localparam int BYTE_LANES  = 4;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LOAD    = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/imem_load_arbiter_word_assembler.sv
// Packs little-endian UART bytes into 32-bit words.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   clear         : synchronous clear of byte count and lanes
//   byte_valid    : accept byte_in this cycle
//   byte_in       : byte placed in lane byte_cnt (lane 0 = [7:0])
//   flush         : end of stream; emit any partial word and clear
//   word_ready    : this cycle's byte completes a word (combinational)
//   flush_ready   : flush with at least one byte pending (combinational)
//   word          : lanes including this cycle's byte, unused lanes zero
module word_assembler
    import imem_load_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    input  logic        flush,
    output logic        word_ready,
    output logic        flush_ready,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt;
    logic [1:0]  cnt_next;
    logic [31:0] lanes;

    always_comb begin
        word = lanes;
        if (byte_valid) begin
            word[{byte_cnt, 3'b000} +: 8] = byte_in;
        end
        cnt_next    = byte_valid ? byte_cnt + 2'd1 : byte_cnt;
        word_ready  = byte_valid && (byte_cnt == 2'(BYTE_LANES - 1));
        flush_ready = flush && (cnt_next != 2'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= '0;
            lanes    <= '0;
        end else if (clear || flush || word_ready) begin
            // Lanes are zeroed after every emitted word so a later partial
            // word carries zeros in its unused upper lanes.
            byte_cnt <= '0;
            lanes    <= '0;
        end else if (byte_valid) begin
            byte_cnt <= cnt_next;
            lanes    <= word;
        end
    end

endmodule

// File: rtl/imem_load_arbiter.sv
// Instruction-ROM port arbiter: shares prgrom between CPU fetch and a UART
// program loader, holding the CPU in reset while a program is loaded.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   load_req          : level request for load mode (edge-qualified in RUN)
//   uart_byte_valid   : strobe, uart_byte valid
//   uart_byte         : received byte, little-endian within each word
//   uart_done         : strobe, loader finished
//   fetch_addr        : CPU fetch word address
//   mem_addr          : prgrom address (fetch_addr in RUN, else load address)
//   mem_we, mem_wdata : prgrom write port, one pulse per word
//   cpu_rst_n         : active-low CPU reset, low while loading
//   loading           : high in LOAD and FLUSH
//   words_loaded      : words written in the current/last session
//   overflow          : sticky per session, byte arrived after last word written
module imem_load_arbiter
    import imem_load_arbiter_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              uart_byte_valid,
    input  logic [7:0]        uart_byte,
    input  logic              uart_done,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst_n,
    output logic              loading,
    output logic [ADDR_W:0]   words_loaded,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] word_addr;
    logic              load_req_q;
    logic              full;
    logic              full_now;
    logic              asm_byte_valid;
    logic              asm_flush;
    logic              word_ready;
    logic              flush_ready;
    logic [31:0]       asm_word;

    // The last word counts as full during its own write cycle so a byte
    // arriving right behind it is already dropped.
    assign full_now       = full || (mem_we && (word_addr == LAST_ADDR));
    assign asm_byte_valid = (state == ST_LOAD) && uart_byte_valid && !full_now;
    assign asm_flush      = (state == ST_LOAD) && uart_done;

    assign mem_addr = (state == ST_RUN) ? fetch_addr : word_addr;
    assign loading  = (state == ST_LOAD) || (state == ST_FLUSH);

    word_assembler u_word_assembler (
        .clk         (clk),
        .rst         (rst),
        .clear       (state == ST_RUN),
        .byte_valid  (asm_byte_valid),
        .byte_in     (uart_byte),
        .flush       (asm_flush),
        .word_ready  (word_ready),
        .flush_ready (flush_ready),
        .word        (asm_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_RUN;
            mem_we       <= 1'b0;
            mem_wdata    <= '0;
            word_addr    <= '0;
            words_loaded <= '0;
            overflow     <= 1'b0;
            full         <= 1'b0;
            cpu_rst_n    <= 1'b0;
            // Treated as already high so a request held through reset must
            // drop before it can start a new session.
            load_req_q   <= 1'b1;
        end else begin
            load_req_q <= load_req;
            mem_we     <= 1'b0;

            // Post-write bookkeeping for the word written this cycle; the
            // address sticks at the last word instead of wrapping.
            if (mem_we) begin
                words_loaded <= words_loaded + (ADDR_W + 1)'(1);
                if (word_addr == LAST_ADDR) begin
                    full <= 1'b1;
                end else begin
                    word_addr <= word_addr + ADDR_W'(1);
                end
            end

            case (state)
                ST_RUN: begin
                    cpu_rst_n <= 1'b1;
                    if (load_req && !load_req_q) begin
                        state        <= ST_LOAD;
                        cpu_rst_n    <= 1'b0;
                        word_addr    <= '0;
                        words_loaded <= '0;
                        overflow     <= 1'b0;
                        full         <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // A partial word is issued on the uart_done edge so its
                    // write lands in the single FLUSH cycle.
                    if (word_ready || flush_ready) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= asm_word;
                    end
                    if (uart_byte_valid && full_now) begin
                        overflow <= 1'b1;
                    end
                    if (uart_done) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    state     <= ST_RUN;
                    cpu_rst_n <= 1'b1;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter: a default-width instance and a
// 4-word instance share all stimulus; writes are logged on negedge.
module tb_imem_load_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_req;
    logic        uart_byte_valid;
    logic [7:0]  uart_byte;
    logic        uart_done;
    logic [13:0] fetch_addr;
    logic [13:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        cpu_rst_n;
    logic        loading;
    logic [14:0] words_loaded;
    logic        overflow;

    logic [1:0]  s_fetch_addr;
    logic [1:0]  s_mem_addr;
    logic        s_mem_we;
    logic [31:0] s_mem_wdata;
    logic        s_cpu_rst_n;
    logic        s_loading;
    logic [2:0]  s_words_loaded;
    logic        s_overflow;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [31:0] swa[$];
    logic [31:0] swd[$];

    always #5 clk = ~clk;

    imem_load_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .load_req        (load_req),
        .uart_byte_valid (uart_byte_valid),
        .uart_byte       (uart_byte),
        .uart_done       (uart_done),
        .fetch_addr      (fetch_addr),
        .mem_addr        (mem_addr),
        .mem_we          (mem_we),
        .mem_wdata       (mem_wdata),
        .cpu_rst_n       (cpu_rst_n),
        .loading         (loading),
        .words_loaded    (words_loaded),
        .overflow        (overflow)
    );

    imem_load_arbiter #(.ADDR_W(2)) dut_small (
        .clk             (clk),
        .rst             (rst),
        .load_req        (load_req),
        .uart_byte_valid (uart_byte_valid),
        .uart_byte       (uart_byte),
        .uart_done       (uart_done),
        .fetch_addr      (s_fetch_addr),
        .mem_addr        (s_mem_addr),
        .mem_we          (s_mem_we),
        .mem_wdata       (s_mem_wdata),
        .cpu_rst_n       (s_cpu_rst_n),
        .loading         (s_loading),
        .words_loaded    (s_words_loaded),
        .overflow        (s_overflow)
    );

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa.push_back(32'(mem_addr));
            wd.push_back(mem_wdata);
        end
        if (s_mem_we === 1'b1) begin
            swa.push_back(32'(s_mem_addr));
            swd.push_back(s_mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_byte       = b;
        uart_byte_valid = 1'b1;
        tick();
        uart_byte_valid = 1'b0;
    endtask

    task automatic clear_logs();
        wa.delete();
        wd.delete();
        swa.delete();
        swd.delete();
    endtask

    initial begin
        rst             = 1'b0;
        load_req        = 1'b0;
        uart_byte_valid = 1'b0;
        uart_byte       = 8'h00;
        uart_done       = 1'b0;
        fetch_addr      = 14'h0123;
        s_fetch_addr    = 2'd1;

        // Reset state
        repeat (2) tick();
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_loading", 32'(loading), 32'd0);

        // 1: RUN passes fetch address through
        rst = 1'b1;
        tick();
        check("t1_addr", 32'(mem_addr), 32'h0123);
        check("t1_we", 32'(mem_we), 32'd0);
        check("t1_cpu_rst_n", 32'(cpu_rst_n), 32'd1);

        // 2: one full word
        load_req = 1'b1;
        tick();
        check("t2_loading", 32'(loading), 32'd1);
        check("t2_cpu_held", 32'(cpu_rst_n), 32'd0);
        check("t2_load_addr", 32'(mem_addr), 32'd0);
        clear_logs();
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        check("t2_we", 32'(mem_we), 32'd1);
        check("t2_waddr", 32'(mem_addr), 32'd0);
        check("t2_wdata", mem_wdata, 32'h12345678);
        tick();
        check("t2_words", 32'(words_loaded), 32'd1);
        check("t2_we_drop", 32'(mem_we), 32'd0);
        uart_done = 1'b1;
        tick();
        uart_done = 1'b0;
        check("t2_flush_we", 32'(mem_we), 32'd0);
        check("t2_flush_loading", 32'(loading), 32'd1);
        tick();
        check("t2_rel_cpu", 32'(cpu_rst_n), 32'd0);
        check("t2_rel_loading", 32'(loading), 32'd0);
        tick();
        check("t2_run_cpu", 32'(cpu_rst_n), 32'd1);
        check("t2_run_addr", 32'(mem_addr), 32'h0123);
        check("t2_nwrites", 32'(wa.size()), 32'd1);
        load_req = 1'b0;
        tick();

        // 3: full word plus a one-byte partial word
        load_req = 1'b1;
        tick();
        clear_logs();
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        send_byte(8'hEE);
        uart_done = 1'b1;
        tick();
        uart_done = 1'b0;
        check("t3_flush_we", 32'(mem_we), 32'd1);
        check("t3_flush_addr", 32'(mem_addr), 32'd1);
        check("t3_flush_wdata", mem_wdata, 32'h000000EE);
        tick();
        check("t3_rel_cpu", 32'(cpu_rst_n), 32'd0);
        check("t3_rel_we", 32'(mem_we), 32'd0);
        check("t3_words", 32'(words_loaded), 32'd2);
        tick();
        check("t3_run_cpu", 32'(cpu_rst_n), 32'd1);
        check("t3_nwrites", 32'(wa.size()), 32'd2);
        check("t3_a0", wa[0], 32'd0);
        check("t3_d0", wd[0], 32'hDDCCBBAA);
        check("t3_a1", wa[1], 32'd1);
        check("t3_d1", wd[1], 32'h000000EE);
        load_req = 1'b0;
        tick();

        // 4: uart_done together with the 4th byte
        load_req = 1'b1;
        tick();
        clear_logs();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        uart_byte       = 8'h04;
        uart_byte_valid = 1'b1;
        uart_done       = 1'b1;
        tick();
        uart_byte_valid = 1'b0;
        uart_done       = 1'b0;
        check("t4_we", 32'(mem_we), 32'd1);
        check("t4_wdata", mem_wdata, 32'h04030201);
        check("t4_loading", 32'(loading), 32'd1);
        tick();
        tick();
        check("t4_words", 32'(words_loaded), 32'd1);
        check("t4_nwrites", 32'(wa.size()), 32'd1);
        check("t4_d0", wd[0], 32'h04030201);
        load_req = 1'b0;
        tick();

        // 5: overflow on the 4-word instance
        load_req = 1'b1;
        tick();
        clear_logs();
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(i + 1));
        end
        tick();
        uart_done = 1'b1;
        tick();
        uart_done = 1'b0;
        tick();
        tick();
        check("t5_s_nwrites", 32'(swa.size()), 32'd4);
        check("t5_s_words", 32'(s_words_loaded), 32'd4);
        check("t5_s_overflow", 32'(s_overflow), 32'd1);
        check("t5_s_a0", swa[0], 32'd0);
        check("t5_s_a3", swa[3], 32'd3);
        check("t5_s_d1", swd[1], 32'h08070605);
        check("t5_s_d3", swd[3], 32'h100F0E0D);
        check("t5_words", 32'(words_loaded), 32'd5);
        check("t5_overflow", 32'(overflow), 32'd0);
        check("t5_d4", wd[4], 32'h00000011);
        load_req = 1'b0;
        tick();

        // 6: async reset mid-word, then edge-qualified re-entry
        load_req = 1'b1;
        tick();
        check("t6_s_ovf_clear", 32'(s_overflow), 32'd0);
        clear_logs();
        send_byte(8'hCA);
        send_byte(8'hFE);
        rst = 1'b0;
        #1;
        check("t6_rst_we", 32'(mem_we), 32'd0);
        check("t6_rst_loading", 32'(loading), 32'd0);
        check("t6_rst_words", 32'(words_loaded), 32'd0);
        check("t6_rst_cpu", 32'(cpu_rst_n), 32'd0);
        check("t6_rst_addr", 32'(mem_addr), 32'h0123);
        #2;
        rst = 1'b1;
        tick();
        tick();
        check("t6_no_reentry", 32'(loading), 32'd0);
        check("t6_cpu", 32'(cpu_rst_n), 32'd1);
        check("t6_nwrites", 32'(wa.size()), 32'd0);
        load_req = 1'b0;
        tick();
        load_req = 1'b1;
        tick();
        check("t6_reentry", 32'(loading), 32'd1);
        send_byte(8'hEF);
        send_byte(8'hBE);
        uart_done = 1'b1;
        tick();
        uart_done = 1'b0;
        check("t6_flush_we", 32'(mem_we), 32'd1);
        check("t6_flush_addr", 32'(mem_addr), 32'd0);
        check("t6_flush_wdata", mem_wdata, 32'h0000BEEF);
        tick();
        tick();
        load_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
